regfile: RTL

Parametrised register bank for the MCU datapath: holds NREGS general-purpose data registers plus opcode, immediate (IMEM), RAM-data (DMEM) and program status (PSR) registers. Feeds both ALU operands through combinational selectors with same-cycle write forwarding. Adds per-flag PSR masking and a one-deep shadow context, saved and restored in one cycle each, for interrupt entry and exit. Sits between the control unit and the ALU, next to the instruction and data memory ports.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_opmux.sv | 32 +++
 rtl/regfile.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared selector offsets, write-source codes and reset opcode for the MCU register bank.
package regfile_pkg;
    // Selector codes above the GPRs are NREGS plus these offsets.
    localparam int REG_IMEM_OFS = 0;
    localparam int REG_DMEM_OFS = 1;
    localparam int REG_PC_OFS   = 2;
    localparam logic [1:0] RES_ALU  = 2'd0;
    localparam logic [1:0] RES_DMEM = 2'd1;
    localparam logic [1:0] RES_IMEM = 2'd2;
    localparam logic [15:0] MCU_LOAD = 16'hF000;
endpackage

// File: rtl/regfile_opmux.sv
// regfile_opmux: ALU operand selector with same-cycle GPR write forwarding.
module regfile_opmux
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NREGS      = 4,
    parameter bit DFLT_IMEM  = 0,
    localparam int AW = $clog2(NREGS),
    localparam int SW = $clog2(NREGS + 3)
) (
    input  logic [SW-1:0]               sel,
    input  logic [NREGS*DATA_WIDTH-1:0] gprs,
    input  logic [DATA_WIDTH-1:0]       imem,
    input  logic [DATA_WIDTH-1:0]       dmem,
    input  logic [DATA_WIDTH-1:0]       pc,
    input  logic                        fwd_en,
    input  logic [AW-1:0]               fwd_addr,
    input  logic [DATA_WIDTH-1:0]       fwd_data,
    output logic [DATA_WIDTH-1:0]       op
);
    localparam logic [SW-1:0] C_IMEM = SW'(NREGS + REG_IMEM_OFS);
    localparam logic [SW-1:0] C_DMEM = SW'(NREGS + REG_DMEM_OFS);
    localparam logic [SW-1:0] C_PC   = SW'(NREGS + REG_PC_OFS);

    always_comb begin
        op = sel == C_IMEM ? imem : sel == C_DMEM ? dmem : sel == C_PC ? pc :
             DFLT_IMEM ? imem : gprs[DATA_WIDTH-1:0];
        for (int i = 0; i < NREGS; i++)
            if (sel == SW'(i))
                op = (fwd_en && fwd_addr == AW'(i)) ? fwd_data : gprs[i*DATA_WIDTH +: DATA_WIDTH];
    end
endmodule

// File: rtl/regfile.sv
// regfile: MCU register bank with GPRs, opcode/IMEM/DMEM/PSR registers,
// forwarded operand selectors and a one-deep shadow context for interrupts.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int INST_WIDTH = 16,
    parameter int INST_DEPTH = 10,
    parameter int NREGS      = 4,
    parameter int APSR_WIDTH = 4,
    localparam int AW = $clog2(NREGS),
    localparam int SW = $clog2(NREGS + 3)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  opcode_update,
    input  logic                  imem_update,
    input  logic [INST_WIDTH-1:0] imem_data,
    input  logic                  dmem_update,
    input  logic [DATA_WIDTH-1:0] dmem_data,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [1:0]            wr_sel,
    input  logic [DATA_WIDTH-1:0] alu,
    input  logic                  psr_update,
    input  logic [APSR_WIDTH-1:0] psr_mask,
    input  logic [APSR_WIDTH-1:0] apsr,
    input  logic [SW-1:0]         opa_sel,
    input  logic [SW-1:0]         opb_sel,
    input  logic [INST_DEPTH-1:0] pc,
    input  logic                  ctx_save,
    input  logic                  ctx_restore,
    output logic [INST_WIDTH-1:0] opcode,
    output logic [APSR_WIDTH-1:0] psr,
    output logic [DATA_WIDTH-1:0] opa,
    output logic [DATA_WIDTH-1:0] opb,
    output logic                  ctx_valid
);
    logic [NREGS-1:0][DATA_WIDTH-1:0] gpr, gpr_nxt, shadow;
    logic [APSR_WIDTH-1:0] psr_nxt, shadow_psr;
    logic [DATA_WIDTH-1:0] imem_q, dmem_q, wdata, pc_d;
    logic restoring;

    // A restore only acts on a valid shadow; otherwise writes proceed normally.
    assign restoring = ctx_restore && ctx_valid;
    assign wdata = (wr_sel == RES_ALU || wr_sel == 2'd3) ? alu :
                   wr_sel == RES_DMEM ? dmem_data : imem_data[DATA_WIDTH-1:0];

    if (INST_DEPTH >= DATA_WIDTH) begin : g_pc_trunc
        assign pc_d = pc[DATA_WIDTH-1:0];
        if (INST_DEPTH > DATA_WIDTH) begin : g_pc_hi
            logic unused_pc;
            assign unused_pc = ^pc[INST_DEPTH-1:DATA_WIDTH];
        end
    end else begin : g_pc_ext
        assign pc_d = {{(DATA_WIDTH - INST_DEPTH){1'b0}}, pc};
    end

    always_comb begin
        gpr_nxt = gpr;
        for (int i = 0; i < NREGS; i++)
            gpr_nxt[i] = restoring ? shadow[i] : (wr_en && wr_addr == AW'(i)) ? wdata : gpr[i];
        psr_nxt = restoring ? shadow_psr : psr_update ? (psr & ~psr_mask) | (apsr & psr_mask) : psr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpr        <= '0;
            shadow     <= '0;
            psr        <= '0;
            shadow_psr <= '0;
            ctx_valid  <= 1'b0;
            imem_q     <= '0;
            dmem_q     <= '0;
            opcode     <= INST_WIDTH'(MCU_LOAD);
        end else begin
            gpr <= gpr_nxt;
            psr <= psr_nxt;
            // Shadow captures next-state so a same-cycle write/flag update is included.
            if (ctx_save && !restoring) begin
                shadow     <= gpr_nxt;
                shadow_psr <= psr_nxt;
            end
            ctx_valid <= restoring ? 1'b0 : ctx_save ? 1'b1 : ctx_valid;
            if (imem_update) imem_q <= imem_data[DATA_WIDTH-1:0];
            if (dmem_update) dmem_q <= dmem_data;
            if (opcode_update) opcode <= imem_data;
        end
    end

    regfile_opmux #(.DATA_WIDTH(DATA_WIDTH), .NREGS(NREGS), .DFLT_IMEM(1'b0)) u_opa (
        .sel(opa_sel), .gprs(gpr), .imem(imem_q), .dmem(dmem_q), .pc(pc_d),
        .fwd_en(wr_en), .fwd_addr(wr_addr), .fwd_data(wdata), .op(opa)
    );

    regfile_opmux #(.DATA_WIDTH(DATA_WIDTH), .NREGS(NREGS), .DFLT_IMEM(1'b1)) u_opb (
        .sel(opb_sel), .gprs(gpr), .imem(imem_q), .dmem(dmem_q), .pc(pc_d),
        .fwd_en(wr_en), .fwd_addr(wr_addr), .fwd_data(wdata), .op(opb)
    );
endmodule
